// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and request-legality helper for the
// load/store unit in front of the word-organised data memory.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
        ERR,
        RESP
    } state_t;

    // Stores only exist as SB/SH/SW; loads add the unsigned byte/half forms.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Core-side request/response bundle of the load/store unit.
interface lsu_dmem_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction with extension, sub-word store merge,
// and natural-alignment check for the access size encoded in funct3.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       lane,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] merged,
    output logic             misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = word[{lane[1], 4'b0000} +: 16];
        load_data = word;
        merged    = store_data;
        misaligned = 1'b0;

        case (funct3)
            F3_B:    load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(WIDTH-16){1'b0}}, half_sel};
            default: load_data = word;
        endcase

        // Size lives in funct3[1:0]; the unsigned bit does not change the lane.
        case (funct3[1:0])
            2'b00: begin
                merged = word;
                merged[{lane, 3'b000} +: 8] = store_data[7:0];
            end
            2'b01: begin
                merged = word;
                merged[{lane[1], 4'b0000} +: 16] = store_data[15:0];
                misaligned = lane[0];
            end
            2'b10:   misaligned = |lane;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit FSM: accepts one byte-addressed request at a time and turns
// it into a word read, word write or read-modify-write on the data memory.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADDRESS = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    lsu_dmem_ctrl_if.slave      req,
    output logic                mem_rw,
    output logic [ADDRESS-1:0]  mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata
);

    state_t             state, state_next;
    logic               we_q;
    logic               err_q;
    logic [2:0]         funct3_q;
    logic [ADDRESS+1:0] addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH-1:0]   merge_q;
    logic [WIDTH-1:0]   rdata_q;

    logic               accept;
    logic               req_bad;
    logic [2:0]         align_funct3;
    logic [1:0]         align_lane;
    logic [WIDTH-1:0]   align_word;
    logic [WIDTH-1:0]   load_data;
    logic [WIDTH-1:0]   merged;
    logic               misaligned;

    assign accept = req.req_valid && (state == IDLE);

    // The aligner checks the incoming request while idle and serves the latched one afterwards.
    assign align_funct3 = (state == IDLE) ? req.req_funct3 : funct3_q;
    assign align_lane   = (state == IDLE) ? req.req_addr[1:0] : addr_q[1:0];
    assign align_word   = (state == RMW_WR) ? merge_q : mem_rdata;

    assign req_bad = !funct3_legal(req.req_we, req.req_funct3) || misaligned
                   || (|req.req_addr[31:ADDRESS+2]);

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .funct3     (align_funct3),
        .lane       (align_lane),
        .word       (align_word),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merged     (merged),
        .misaligned (misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req.req_valid) begin
                    if (req_bad)                  state_next = ERR;
                    else if (!req.req_we)         state_next = LOAD;
                    else if (req.req_funct3 == F3_W) state_next = WRITE;
                    else                          state_next = RMW_RD;
                end
            end
            LOAD, WRITE, RMW_WR, ERR: state_next = RESP;
            RMW_RD:                   state_next = RMW_WR;
            RESP:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req.req_we;
                err_q    <= req_bad;
                funct3_q <= req.req_funct3;
                addr_q   <= req.req_addr[ADDRESS+1:0];
                wdata_q  <= req.req_wdata;
                rdata_q  <= '0;
            end
            if (state == LOAD && !we_q) rdata_q <= load_data;
            if (state == RMW_RD)        merge_q <= mem_rdata;
        end
    end

    // Memory is written only from WRITE and RMW_WR; every other state reads.
    always_comb begin
        req.req_ready = (state == IDLE);
        req.rsp_valid = (state == RESP);
        req.rsp_err   = (state == RESP) && err_q;
        req.rsp_rdata = (state == RESP) ? rdata_q : '0;
        mem_rw        = MEM_READ;
        mem_addr      = addr_q[ADDRESS+1:2];
        mem_wdata     = '0;
        case (state)
            WRITE: begin
                mem_rw    = MEM_WRITE;
                mem_wdata = wdata_q;
            end
            RMW_WR: begin
                mem_rw    = MEM_WRITE;
                mem_wdata = merged;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store unit between the core's memory-stage request and the word-organised data memory (10-bit word address, single read/write select, combinational read, write on clock edge). Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses. Sub-word stores use a read-modify-write sequence. Misaligned, out-of-range and illegal requests are flagged with an error response and never reach memory.

Parameters:
WIDTH, 32, data word width
ADDRESS, 10, memory word-address width; byte window = 2^(ADDRESS+2) bytes

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  32  byte address
req_wdata  input  WIDTH  store data, right-justified
rsp_valid  output  1  one-cycle response pulse
rsp_err  output  1  valid with rsp_valid: misaligned, out-of-range or illegal funct3
rsp_rdata  output  WIDTH  extended load data, valid with rsp_valid; 0 for stores and errors
mem_rw  output  1  to memory: 0 = read, 1 = write
mem_addr  output  ADDRESS  word address = latched addr[ADDRESS+1:2]
mem_wdata  output  WIDTH  word to write
mem_rdata  input  WIDTH  combinational read data from memory

Behaviour:
- Reset (async, reset_n low): state IDLE. req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_rw=0, mem_addr=0, mem_wdata=0. All latched request registers cleared.
- mem_rw is 1 only in WRITE and RMW_WR. It is 0 in every other state, so memory is never written spuriously.
- IDLE: req_ready=1. On acceptance, latch we, funct3, addr and wdata, then check the request:
  - Illegal funct3 (load: 011, 110, 111; store: anything other than 000/001/010) -> ERR.
  - Misaligned (half-word with addr[0]=1, word with addr[1:0]!=0) -> ERR.
  - Out of range (addr[31:ADDRESS+2]!=0) -> ERR.
  - Otherwise: load -> LOAD, SW -> WRITE, SB/SH -> RMW_RD.
- LOAD: drive mem_addr. Register the byte/half/word selected by addr[1:0] from mem_rdata, sign- or zero-extended per funct3. -> RESP.
- WRITE: mem_rw=1, mem_wdata=req_wdata. -> RESP.
- RMW_RD: mem_rw=0. Capture mem_rdata into the merge register. -> RMW_WR.
- RMW_WR: mem_rw=1. mem_wdata = merge register with req_wdata[7:0] (SB) or [15:0] (SH) inserted at lane addr[1:0]. Other bytes are preserved. -> RESP.
- ERR: -> RESP with rsp_err=1 and rsp_rdata=0. No memory cycle issued.
- RESP: rsp_valid=1 for exactly one cycle; req_ready=0. -> IDLE.
- Latency, counted from the acceptance edge N:
  - Error: rsp_valid in cycle N+2 (via ERR).
  - Load / SW: rsp_valid in cycle N+2.
  - SB / SH: rsp_valid in cycle N+3.
  - Throughput: one request per latency+1 cycles.
- req_ready=0 in every state except IDLE. req_valid while busy is ignored and not latched.
- There is no response back-pressure; the consumer must take rsp in its valid cycle.
- Reset asserted mid-sequence aborts immediately. An RMW interrupted before RMW_WR leaves memory untouched. No response is produced for an aborted request.
- Byte lanes are little-endian: lane k = bits [8k+7:8k].

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, ERR, RESP.
  - Memory-select constants: MEM_READ=0, MEM_WRITE=1.
- One combinational sub-module, lsu_align. Inputs: funct3, addr[1:0], word, store data. Outputs: extended load data, merged store word, misaligned flag. The FSM lives in lsu_dmem_ctrl.

Test Plan:
- Reset, then SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> memory word 4 = 0xDEADBEEF. LW rsp_rdata=0xDEADBEEF and rsp_err=0. rsp_valid arrives 2 cycles after acceptance.
- Preload word 4 = 0x11223344. SB addr 0x013 data 0xAA -> word becomes 0xAA223344; mem_rw high for exactly one cycle; response 3 cycles after acceptance.
- Word 4 = 0x8000F0FF. LB 0x010 -> 0xFFFFFFFF; LBU 0x010 -> 0x000000FF; LH 0x012 -> 0xFFFF8000; LHU 0x012 -> 0x00008000.
- Misaligned and illegal requests: LW 0x012, SH 0x011, LB 0x1000 (out of range), funct3=011 load. Each gives rsp_err=1, rsp_rdata=0, mem_rw never 1, memory unchanged.
- Hold req_valid high continuously with 3 queued requests -> exactly one accepted per IDLE visit; req_ready=0 while busy; no request lost or duplicated.
- Assert reset_n low during RMW_RD of SH 0x020 -> outputs return to reset values asynchronously. No write occurs to word 8. First request after reset is accepted normally.
